// File: rtl/pl_rv32_fetch.sv
// pl_rv32_fetch
// Instruction fetch stage of the pipelined RV32 core. It owns the program
// counter and issues word reads to instruction memory with a req/gnt/rvalid
// handshake, keeping at most one request outstanding. Returned words go into
// a 2-entry {instr, pc} queue that feeds decode over a valid/ready interface.
// A redirect from branch/jump resolution flushes the queue, restarts fetch at
// the new PC, and discards any response still in flight for the old path.
//
// Ports:
//   clk, rst                    core clock, asynchronous active-high reset
//   redirect_valid/redirect_pc  one-cycle restart request; pc[1:0] ignored
//   imem_req/imem_addr          read request and word-aligned address
//   imem_gnt                    memory accepted the request this cycle
//   imem_rvalid/imem_rdata      read response, one per accepted request
//   id_valid/id_instr/id_pc     queue head toward decode (NOP when empty)
//   id_ready                    decode consumes the head this cycle
module pl_rv32_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [31:0]       pc_q, pc_d;
  logic [31:0]       pend_pc_q, pend_pc_d;
  logic              drop_q, drop_d;
  logic [1:0]        count_q, count_d;
  logic [1:0][31:0]  qi_q, qi_d;
  logic [1:0][31:0]  qp_q, qp_d;

  logic              deq;
  logic              enq;
  logic [1:0]        cnt_after_deq;

  // The low redirect address bits are architecturally ignored.
  logic              unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // State register and queue storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      pend_pc_q <= RESET_PC;
      drop_q    <= 1'b0;
      count_q   <= 2'd0;
      qi_q      <= {NOP_INSTR, NOP_INSTR};
      qp_q      <= {RESET_PC, RESET_PC};
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      pend_pc_q <= pend_pc_d;
      drop_q    <= drop_d;
      count_q   <= count_d;
      qi_q      <= qi_d;
      qp_q      <= qp_d;
    end
  end

  // Next-state logic: queue push/pop first, then the fetch FSM, and finally
  // the redirect overrides, since a redirect beats every other event.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    pend_pc_d = pend_pc_q;
    drop_d    = drop_q;
    qi_d      = qi_q;
    qp_d      = qp_q;

    deq = (count_q != 2'd0) && id_ready && !redirect_valid;
    enq = (state_q == WAIT) && imem_rvalid && !drop_q && !redirect_valid;
    cnt_after_deq = count_q - {1'b0, deq};

    // Queue is a shift register: entry 0 is always the head, so the write
    // slot is simply the occupancy left after this cycle's pop.
    if (deq) begin
      qi_d[0] = qi_q[1];
      qp_d[0] = qp_q[1];
    end
    if (enq) begin
      qi_d[cnt_after_deq[0]] = imem_rdata;
      qp_d[cnt_after_deq[0]] = pend_pc_q;
    end
    count_d = cnt_after_deq + {1'b0, enq};

    case (state_q)
      IDLE: begin
        if (cnt_after_deq < 2'd2) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (imem_gnt) begin
          pc_d      = pc_q + 32'd4;
          pend_pc_d = pc_q;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          drop_d  = 1'b0;
          state_d = (count_d < 2'd2) ? REQ : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A granted or still-pending request on the old path must have its
    // response swallowed, so the drop flag is armed and we keep waiting.
    if (redirect_valid) begin
      count_d = 2'd0;
      pc_d    = {redirect_pc[31:2], 2'b00};
      case (state_q)
        REQ: begin
          if (imem_gnt) begin
            drop_d  = 1'b1;
            state_d = WAIT;
          end else begin
            state_d = REQ;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            drop_d  = 1'b0;
            state_d = REQ;
          end else begin
            drop_d  = 1'b1;
            state_d = WAIT;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  // Outputs come straight from registers; no input reaches them combinationally.
  assign imem_req  = (state_q == REQ);
  assign imem_addr = pc_q;
  assign id_valid  = (count_q != 2'd0);
  assign id_instr  = id_valid ? qi_q[0] : NOP_INSTR;
  assign id_pc     = qp_q[0];

endmodule
